// File: rtl/pe_seq_if.sv
// Controller <-> PE datapath bundle: buffer/traversal status and psum handshake in, sequencing strobes out.
// The master side is the controller; the datapath and psum memory sit on the slave side.
interface pe_seq_if #(
  parameter int FILTER_ADDR_WIDTH = 8,
  parameter int PIPE_DEPTH        = 3
);
  localparam int FILL_W = $clog2(PIPE_DEPTH + 1);

  logic                         start;
  logic                         IF_empty;
  logic                         reading_empty;
  logic                         filter_cannot_read;
  logic [FILTER_ADDR_WIDTH-1:0] filter_waddr;
  logic                         sp_valid;
  logic                         f_co;
  logic                         go_next_stride;
  logic                         stride_ended;
  logic                         ended;
  logic                         go_next_filter;
  logic                         is_last_filter;
  logic                         psum_mode;
  logic                         psum_valid;
  logic                         psum_ready;
  logic                         psum_w_co;
  logic                         error;

  logic                         chip_en;
  logic                         global_rst;
  logic                         en_p_traverse;
  logic                         ren;
  logic                         ld_IF;
  logic                         i_en;
  logic                         mult_en;
  logic                         ld_result;
  logic                         en_f_counter;
  logic                         rst_f_counter;
  logic                         next_stride;
  logic                         next_filter;
  logic                         rst_stride;
  logic                         next_start;
  logic                         make_empty;
  logic                         rst_if_ctx;
  logic                         psum_ren;
  logic                         psum_wen;
  logic                         next_psum_raddr;
  logic                         next_psum_waddr;
  logic                         rst_psum_raddr;
  logic                         done;
  logic                         stall_signal;
  logic                         busy;
  logic                         timeout_err;
  logic [FILL_W-1:0]            fill_level;

  modport master (
    input  start, IF_empty, reading_empty, filter_cannot_read, filter_waddr, sp_valid,
           f_co, go_next_stride, stride_ended, ended, go_next_filter, is_last_filter,
           psum_mode, psum_valid, psum_ready, psum_w_co, error,
    output chip_en, global_rst, en_p_traverse, ren, ld_IF, i_en, mult_en, ld_result,
           en_f_counter, rst_f_counter, next_stride, next_filter, rst_stride, next_start,
           make_empty, rst_if_ctx, psum_ren, psum_wen, next_psum_raddr, next_psum_waddr,
           rst_psum_raddr, done, stall_signal, busy, timeout_err, fill_level
  );

  modport slave (
    output start, IF_empty, reading_empty, filter_cannot_read, filter_waddr, sp_valid,
           f_co, go_next_stride, stride_ended, ended, go_next_filter, is_last_filter,
           psum_mode, psum_valid, psum_ready, psum_w_co, error,
    input  chip_en, global_rst, en_p_traverse, ren, ld_IF, i_en, mult_en, ld_result,
           en_f_counter, rst_f_counter, next_stride, next_filter, rst_stride, next_start,
           make_empty, rst_if_ctx, psum_ren, psum_wen, next_psum_raddr, next_psum_waddr,
           rst_psum_raddr, done, stall_signal, busy, timeout_err, fill_level
  );
endinterface

// File: rtl/pe_seq_controller.sv
// PE sequencer: arm, find start pointer, fill/run/drain the PIPE_DEPTH pipeline, commit psum over valid/ready.
// Strobes are combinational from registered state; freeze stalls FILL/RUN, psum waits are watchdog-bounded.
module pe_seq_controller #(
  parameter int FILTER_ADDR_WIDTH = 8,
  parameter int PIPE_DEPTH        = 3,
  parameter int WAIT_LIMIT        = 255
) (
  input  logic     clk,
  input  logic     reset,
  pe_seq_if.master bus
);
  localparam int FILL_W = $clog2(PIPE_DEPTH + 1);
  localparam int WAIT_W = $clog2(WAIT_LIMIT + 1);
  localparam logic [FILL_W-1:0] FILL_PRE = FILL_W'(PIPE_DEPTH - 2);
  localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(WAIT_LIMIT - 1);

  typedef enum logic [3:0] {
    S_IDLE, S_ARM, S_WAIT_DATA, S_FIND_SP, S_FILL, S_RUN, S_DRAIN,
    S_PSUM_RD, S_PSUM_WR, S_NEXT_IF, S_UPDATE_SP, S_DONE, S_ERROR
  } state_t;

  state_t              state, state_nxt;
  logic [FILL_W-1:0]   fill_q;
  logic [WAIT_W-1:0]   wait_cnt;
  logic                timeout_q;
  logic                timeout_hit;

  logic freeze, run, in_wait, wait_hit;
  assign freeze   = bus.reading_empty | bus.filter_cannot_read | !bus.sp_valid;
  assign run      = !freeze & !bus.f_co;
  assign in_wait  = (state == S_PSUM_RD) || (state == S_PSUM_WR);
  assign wait_hit = (wait_cnt == WAIT_MAX);

  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt   = state;
    timeout_hit = 1'b0;
    case (state)
      S_IDLE:      if (bus.start) state_nxt = S_ARM;
      S_ARM:       if (!bus.start) state_nxt = S_WAIT_DATA;
      S_WAIT_DATA: if (!bus.IF_empty && bus.filter_waddr != {FILTER_ADDR_WIDTH{1'b0}})
                     state_nxt = S_FIND_SP;
      S_FIND_SP:   if (bus.sp_valid) state_nxt = S_FILL;
      S_FILL:      if (!freeze && fill_q >= FILL_PRE) state_nxt = S_RUN;
      S_RUN: begin
        // Layer-level filter advance outranks the window end.
        if (bus.go_next_filter && bus.is_last_filter) state_nxt = S_NEXT_IF;
        else if (bus.f_co && !freeze)                 state_nxt = S_DRAIN;
      end
      S_DRAIN:     if (fill_q <= FILL_W'(1)) state_nxt = bus.psum_mode ? S_PSUM_RD : S_PSUM_WR;
      S_PSUM_RD: begin
        if (bus.psum_valid) state_nxt = S_PSUM_WR;
        else if (wait_hit) begin
          state_nxt   = S_ERROR;
          timeout_hit = 1'b1;
        end
      end
      S_PSUM_WR: begin
        if (bus.psum_ready) state_nxt = bus.psum_w_co ? S_DONE : S_FILL;
        else if (wait_hit) begin
          state_nxt   = S_ERROR;
          timeout_hit = 1'b1;
        end
      end
      S_NEXT_IF:   state_nxt = S_UPDATE_SP;
      S_UPDATE_SP: state_nxt = S_FILL;
      S_DONE:      state_nxt = S_IDLE;
      S_ERROR:     state_nxt = S_ERROR;
      default:     state_nxt = S_IDLE;
    endcase
    if (bus.error && state != S_IDLE) state_nxt = S_ERROR;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      fill_q <= '0;
    end else begin
      case (state)
        S_ARM:     fill_q <= '0;
        S_FILL:    if (!freeze) fill_q <= fill_q + FILL_W'(1);
        S_DRAIN:   if (fill_q != '0) fill_q <= fill_q - FILL_W'(1);
        S_NEXT_IF: fill_q <= '0;
        default:   fill_q <= fill_q;
      endcase
    end
  end

  // Any state change restarts the count, so RD->WR gets a fresh budget.
  always_ff @(posedge clk) begin
    if (reset)                   wait_cnt <= '0;
    else if (state_nxt != state) wait_cnt <= '0;
    else if (in_wait)            wait_cnt <= wait_cnt + WAIT_W'(1);
    else                         wait_cnt <= '0;
  end

  always_ff @(posedge clk) begin
    if (reset)            timeout_q <= 1'b0;
    else if (timeout_hit) timeout_q <= 1'b1;
  end

  logic o_global_rst, o_en_p_traverse, o_ren, o_ld_IF, o_i_en, o_mult_en, o_ld_result;
  logic o_en_f_counter, o_rst_f_counter, o_next_stride, o_next_filter, o_rst_stride;
  logic o_next_start, o_make_empty, o_rst_if_ctx, o_psum_ren, o_psum_wen;
  logic o_next_psum_raddr, o_next_psum_waddr, o_rst_psum_raddr, o_done, o_stall;

  always_comb begin
    o_global_rst = 1'b0; o_en_p_traverse = 1'b0; o_ren = 1'b0; o_ld_IF = 1'b0;
    o_i_en = 1'b0; o_mult_en = 1'b0; o_ld_result = 1'b0; o_en_f_counter = 1'b0;
    o_rst_f_counter = 1'b0; o_next_stride = 1'b0; o_next_filter = 1'b0; o_rst_stride = 1'b0;
    o_next_start = 1'b0; o_make_empty = 1'b0; o_rst_if_ctx = 1'b0; o_psum_ren = 1'b0;
    o_psum_wen = 1'b0; o_next_psum_raddr = 1'b0; o_next_psum_waddr = 1'b0;
    o_rst_psum_raddr = 1'b0; o_done = 1'b0; o_stall = 1'b0;
    case (state)
      S_ARM:     o_global_rst = 1'b1;
      S_FIND_SP: o_en_p_traverse = !bus.sp_valid;
      S_FILL: begin
        if (!freeze) begin
          o_ren     = 1'b1;
          o_ld_IF   = 1'b1;
          o_i_en    = 1'b1;
          o_mult_en = (fill_q != '0);
        end
      end
      S_RUN: begin
        o_ren          = run;
        o_ld_IF        = run;
        o_i_en         = run;
        o_mult_en      = run;
        o_ld_result    = run;
        o_en_f_counter = run;
        o_next_stride  = run & bus.go_next_stride & !bus.stride_ended & !bus.ended;
        o_next_filter  = !freeze & bus.go_next_filter;
        o_rst_stride   = !freeze & bus.go_next_filter;
      end
      S_DRAIN: begin
        o_ld_result = 1'b1;
        o_mult_en   = 1'b1;
      end
      S_PSUM_RD: o_psum_ren = 1'b1;
      S_PSUM_WR: begin
        o_psum_wen = 1'b1;
        if (bus.psum_ready) begin
          o_next_psum_waddr = 1'b1;
          o_rst_f_counter   = 1'b1;
          o_next_psum_raddr = bus.psum_mode;
        end
      end
      S_NEXT_IF: begin
        o_make_empty = 1'b1;
        o_rst_if_ctx = 1'b1;
        o_rst_stride = 1'b1;
      end
      S_UPDATE_SP: begin
        o_next_start     = 1'b1;
        o_rst_psum_raddr = bus.psum_mode;
      end
      S_DONE:  o_done  = 1'b1;
      S_ERROR: o_stall = 1'b1;
      default: ;
    endcase
  end

  assign bus.chip_en         = (state != S_IDLE);
  assign bus.busy            = (state != S_IDLE);
  assign bus.global_rst      = o_global_rst;
  assign bus.en_p_traverse   = o_en_p_traverse;
  assign bus.ren             = o_ren;
  assign bus.ld_IF           = o_ld_IF;
  assign bus.i_en            = o_i_en;
  assign bus.mult_en         = o_mult_en;
  assign bus.ld_result       = o_ld_result;
  assign bus.en_f_counter    = o_en_f_counter;
  assign bus.rst_f_counter   = o_rst_f_counter;
  assign bus.next_stride     = o_next_stride;
  assign bus.next_filter     = o_next_filter;
  assign bus.rst_stride      = o_rst_stride;
  assign bus.next_start      = o_next_start;
  assign bus.make_empty      = o_make_empty;
  assign bus.rst_if_ctx      = o_rst_if_ctx;
  assign bus.psum_ren        = o_psum_ren;
  assign bus.psum_wen        = o_psum_wen;
  assign bus.next_psum_raddr = o_next_psum_raddr;
  assign bus.next_psum_waddr = o_next_psum_waddr;
  assign bus.rst_psum_raddr  = o_rst_psum_raddr;
  assign bus.done            = o_done;
  assign bus.stall_signal    = o_stall;
  assign bus.timeout_err     = timeout_q;
  assign bus.fill_level      = fill_q;
endmodule

// File: tb/tb_pe_seq_controller.sv
// Directed bench: PIPE_DEPTH=3 and PIPE_DEPTH=5 controllers (WAIT_LIMIT=8) fed from shared stimulus.
module tb_pe_seq_controller;
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic start, IF_empty, reading_empty, filter_cannot_read, sp_valid;
  logic [7:0] filter_waddr;
  logic f_co, go_next_stride, stride_ended, ended, go_next_filter, is_last_filter;
  logic psum_mode, psum_valid, psum_ready, psum_w_co, error;

  int n_tests = 0;
  int n_fail  = 0;

  pe_seq_if #(.FILTER_ADDR_WIDTH(8), .PIPE_DEPTH(3)) if3 ();
  pe_seq_if #(.FILTER_ADDR_WIDTH(8), .PIPE_DEPTH(5)) if5 ();

  pe_seq_controller #(.FILTER_ADDR_WIDTH(8), .PIPE_DEPTH(3), .WAIT_LIMIT(8)) dut3 (
    .clk(clk), .reset(reset), .bus(if3.master));
  pe_seq_controller #(.FILTER_ADDR_WIDTH(8), .PIPE_DEPTH(5), .WAIT_LIMIT(8)) dut5 (
    .clk(clk), .reset(reset), .bus(if5.master));

  assign if3.start = start;                   assign if5.start = start;
  assign if3.IF_empty = IF_empty;             assign if5.IF_empty = IF_empty;
  assign if3.reading_empty = reading_empty;   assign if5.reading_empty = reading_empty;
  assign if3.filter_cannot_read = filter_cannot_read;
  assign if5.filter_cannot_read = filter_cannot_read;
  assign if3.filter_waddr = filter_waddr;     assign if5.filter_waddr = filter_waddr;
  assign if3.sp_valid = sp_valid;             assign if5.sp_valid = sp_valid;
  assign if3.f_co = f_co;                     assign if5.f_co = f_co;
  assign if3.go_next_stride = go_next_stride; assign if5.go_next_stride = go_next_stride;
  assign if3.stride_ended = stride_ended;     assign if5.stride_ended = stride_ended;
  assign if3.ended = ended;                   assign if5.ended = ended;
  assign if3.go_next_filter = go_next_filter; assign if5.go_next_filter = go_next_filter;
  assign if3.is_last_filter = is_last_filter; assign if5.is_last_filter = is_last_filter;
  assign if3.psum_mode = psum_mode;           assign if5.psum_mode = psum_mode;
  assign if3.psum_valid = psum_valid;         assign if5.psum_valid = psum_valid;
  assign if3.psum_ready = psum_ready;         assign if5.psum_ready = psum_ready;
  assign if3.psum_w_co = psum_w_co;           assign if5.psum_w_co = psum_w_co;
  assign if3.error = error;                   assign if5.error = error;

  logic [26:0] all3;
  logic [27:0] all5;
  assign all3 = {if3.chip_en, if3.global_rst, if3.en_p_traverse, if3.ren, if3.ld_IF, if3.i_en,
                 if3.mult_en, if3.ld_result, if3.en_f_counter, if3.rst_f_counter, if3.next_stride,
                 if3.next_filter, if3.rst_stride, if3.next_start, if3.make_empty, if3.rst_if_ctx,
                 if3.psum_ren, if3.psum_wen, if3.next_psum_raddr, if3.next_psum_waddr,
                 if3.rst_psum_raddr, if3.done, if3.stall_signal, if3.busy, if3.timeout_err,
                 if3.fill_level};
  assign all5 = {if5.chip_en, if5.global_rst, if5.en_p_traverse, if5.ren, if5.ld_IF, if5.i_en,
                 if5.mult_en, if5.ld_result, if5.en_f_counter, if5.rst_f_counter, if5.next_stride,
                 if5.next_filter, if5.rst_stride, if5.next_start, if5.make_empty, if5.rst_if_ctx,
                 if5.psum_ren, if5.psum_wen, if5.next_psum_raddr, if5.next_psum_waddr,
                 if5.rst_psum_raddr, if5.done, if5.stall_signal, if5.busy, if5.timeout_err,
                 if5.fill_level};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(negedge clk);
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; IF_empty = 1'b1; reading_empty = 1'b0; filter_cannot_read = 1'b0;
    filter_waddr = 8'd0; sp_valid = 1'b0; f_co = 1'b0; go_next_stride = 1'b0;
    stride_ended = 1'b0; ended = 1'b0; go_next_filter = 1'b0; is_last_filter = 1'b0;
    psum_mode = 1'b0; psum_valid = 1'b0; psum_ready = 1'b0; psum_w_co = 1'b0; error = 1'b0;
    repeat (2) @(posedge clk);

    // IDLE after reset, then start pulse
    cyc(); reset = 1'b0; start = 1'b1; #1;
    chk("reset_all_zero", 32'(all3), 32'd0);
    cyc(); start = 1'b0; #1;
    chk("arm_global_rst", 32'(if3.global_rst), 32'd1);
    chk("arm_busy", 32'({if3.chip_en, if3.busy}), 32'b11);
    cyc(); IF_empty = 1'b0; #1;
    chk("wait_data_no_rst", 32'(if3.global_rst), 32'd0);
    cyc(); filter_waddr = 8'd5; #1;
    chk("waddr_zero_holds", 32'(if3.en_p_traverse), 32'd0);
    cyc(); #1;
    chk("find_sp_traverse", 32'(if3.en_p_traverse), 32'd1);
    cyc(); sp_valid = 1'b1; #1;
    chk("find_sp_found", 32'(if3.en_p_traverse), 32'd0);

    // FILL: two cycles, mult_en joins on the second
    cyc(); #1;
    chk("fill0_strobes", 32'({if3.ren, if3.ld_IF, if3.i_en, if3.mult_en, if3.ld_result}), 32'b11100);
    chk("fill0_level", 32'(if3.fill_level), 32'd0);
    cyc(); #1;
    chk("fill1_strobes", 32'({if3.ren, if3.ld_IF, if3.i_en, if3.mult_en, if3.ld_result}), 32'b11110);
    chk("fill1_level", 32'(if3.fill_level), 32'd1);

    // RUN: first ld_result two cycles after FILL entry
    cyc(); go_next_stride = 1'b1; #1;
    chk("run_first_ld_result", 32'({if3.ren, if3.ld_IF, if3.i_en, if3.mult_en, if3.ld_result,
                                     if3.en_f_counter}), 32'b111111);
    chk("run_fill_level", 32'(if3.fill_level), 32'd2);
    chk("next_stride", 32'(if3.next_stride), 32'd1);
    cyc(); stride_ended = 1'b1; #1;
    chk("next_stride_blocked", 32'(if3.next_stride), 32'd0);

    for (int i = 0; i < 4; i++) begin
      cyc(); go_next_stride = 1'b0; stride_ended = 1'b0; reading_empty = 1'b1; #1;
      chk("freeze_strobes", 32'({if3.ren, if3.ld_IF, if3.ld_result}), 32'd0);
      chk("freeze_fill_level", 32'(if3.fill_level), 32'd2);
    end
    cyc(); reading_empty = 1'b0; #1;
    chk("unfreeze_ld_result", 32'({if3.ren, if3.ld_IF, if3.ld_result}), 32'b111);
    cyc(); go_next_filter = 1'b1; #1;
    chk("next_filter", 32'({if3.next_filter, if3.rst_stride}), 32'b11);
    cyc(); go_next_filter = 1'b0; f_co = 1'b1; #1;
    chk("fco_run_low", 32'({if3.ld_result, if3.en_f_counter}), 32'd0);

    // DRAIN ignores freeze
    cyc(); f_co = 1'b0; reading_empty = 1'b1; #1;
    chk("drain0", 32'({if3.ren, if3.mult_en, if3.ld_result}), 32'b011);
    chk("drain0_level", 32'(if3.fill_level), 32'd2);
    cyc(); reading_empty = 1'b0; #1;
    chk("drain1", 32'({if3.ren, if3.mult_en, if3.ld_result}), 32'b011);
    chk("drain1_level", 32'(if3.fill_level), 32'd1);
    cyc(); psum_ready = 1'b1; #1;
    chk("wr_accept", 32'({if3.psum_wen, if3.next_psum_waddr, if3.rst_f_counter,
                          if3.next_psum_raddr}), 32'b1110);
    cyc(); psum_ready = 1'b0; #1;
    chk("back_to_fill", 32'({if3.ren, if3.mult_en, if3.psum_wen}), 32'b100);
    chk("back_to_fill_level", 32'(if3.fill_level), 32'd0);

    // Accumulate window: read 3 cycles, write 2 cycles
    cyc(); #1;
    cyc(); f_co = 1'b1; psum_mode = 1'b1; #1;
    chk("run2_level", 32'(if3.fill_level), 32'd2);
    cyc(); f_co = 1'b0; #1;
    chk("drain_acc0", 32'(if3.ld_result), 32'd1);
    cyc(); #1;
    chk("drain_acc1_level", 32'(if3.fill_level), 32'd1);
    for (int i = 0; i < 3; i++) begin
      cyc(); psum_valid = (i == 2); #1;
      chk("psum_ren", 32'({if3.psum_ren, if3.psum_wen}), 32'b10);
    end
    cyc(); psum_valid = 1'b0; #1;
    chk("wr_wait", 32'({if3.psum_wen, if3.next_psum_waddr, if3.next_psum_raddr}), 32'b100);
    cyc(); psum_ready = 1'b1; #1;
    chk("wr_accept_acc", 32'({if3.psum_wen, if3.next_psum_waddr, if3.next_psum_raddr}), 32'b111);
    cyc(); psum_ready = 1'b0; #1;
    chk("raddr_single_pulse", 32'({if3.next_psum_raddr, if3.psum_wen, if3.ren}), 32'b001);

    // Last filter together with f_co: NEXT_IF wins
    cyc(); #1;
    cyc(); go_next_filter = 1'b1; is_last_filter = 1'b1; f_co = 1'b1; #1;
    chk("run_last_filter", 32'(if3.next_filter), 32'd1);
    cyc(); go_next_filter = 1'b0; is_last_filter = 1'b0; f_co = 1'b0; #1;
    chk("next_if", 32'({if3.make_empty, if3.rst_if_ctx, if3.rst_stride, if3.ld_result}), 32'b1110);
    cyc(); #1;
    chk("update_sp", 32'({if3.next_start, if3.rst_psum_raddr}), 32'b11);
    chk("update_sp_level", 32'(if3.fill_level), 32'd0);
    cyc(); psum_mode = 1'b0; #1;
    chk("fill_after_sp", 32'({if3.ren, if3.mult_en, if3.next_start}), 32'b100);

    // Final window with psum_w_co
    cyc(); #1;
    cyc(); f_co = 1'b1; #1;
    cyc(); f_co = 1'b0; #1;
    cyc(); #1;
    cyc(); psum_ready = 1'b1; psum_w_co = 1'b1; #1;
    chk("final_write", 32'(if3.next_psum_waddr), 32'd1);
    cyc(); psum_ready = 1'b0; psum_w_co = 1'b0; #1;
    chk("done_pulse", 32'({if3.done, if3.busy}), 32'b11);
    cyc(); start = 1'b1; #1;
    chk("idle_after_done", 32'({if3.done, if3.busy}), 32'd0);

    // Second run: psum_ready never arrives -> watchdog
    cyc(); start = 1'b0; #1;
    cyc(); #1;
    cyc(); #1;
    cyc(); #1;
    cyc(); #1;
    cyc(); f_co = 1'b1; #1;
    cyc(); f_co = 1'b0; #1;
    cyc(); #1;
    for (int i = 0; i < 8; i++) begin
      cyc(); #1;
      chk("timeout_wait", 32'({if3.psum_wen, if3.stall_signal, if3.timeout_err}), 32'b100);
    end
    cyc(); #1;
    chk("timeout_error", 32'({if3.stall_signal, if3.timeout_err, if3.psum_wen, if3.chip_en}), 32'b1101);
    cyc(); psum_ready = 1'b1; #1;
    chk("error_sticky", 32'({if3.stall_signal, if3.timeout_err}), 32'b11);
    psum_ready = 1'b0; reset = 1'b1;
    cyc(); reset = 1'b0; start = 1'b1; #1;
    chk("reset_from_error", 32'(all3), 32'd0);
    chk("reset_dut5", 32'(all5), 32'd0);

    // PIPE_DEPTH=5 regression
    cyc(); start = 1'b0; #1;
    chk("d5_arm", 32'(if5.global_rst), 32'd1);
    cyc(); #1;
    cyc(); #1;
    for (int i = 0; i < 4; i++) begin
      cyc(); #1;
      chk("d5_fill_level", 32'(if5.fill_level), 32'(i));
      chk("d5_fill_no_ld", 32'(if5.ld_result), 32'd0);
    end
    cyc(); #1;
    chk("d5_run_peak", 32'(if5.fill_level), 32'd4);
    chk("d5_run_ld_result", 32'(if5.ld_result), 32'd1);
    cyc(); f_co = 1'b1; #1;
    for (int i = 0; i < 4; i++) begin
      cyc(); f_co = 1'b0; #1;
      chk("d5_drain", 32'({if5.ld_result, if5.mult_en, if5.ren}), 32'b110);
      chk("d5_drain_level", 32'(if5.fill_level), 32'(4 - i));
    end
    for (int i = 0; i < 7; i++) begin
      cyc(); #1;
      chk("d5_wr_wait", 32'({if5.psum_wen, if5.next_psum_waddr}), 32'b10);
    end
    cyc(); psum_ready = 1'b1; #1;
    chk("d5_limit_handshake_wins", 32'({if5.next_psum_waddr, if5.stall_signal}), 32'b10);
    cyc(); psum_ready = 1'b0; #1;
    chk("d5_fill_after_wr", 32'({if5.ren, if5.stall_signal, if5.timeout_err}), 32'b100);
    error = 1'b1;
    cyc(); error = 1'b0; #1;
    chk("d5_error_input", 32'({if5.stall_signal, if5.timeout_err, if5.busy}), 32'b101);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/pe_seq_controller.md
# pe_seq_controller

Parametrised sequencing controller for one convolution PE, the next generation of the PE main controller. It arms on a start pulse, locates the start pointer, fills a `PIPE_DEPTH`-stage IFMAP×filter pipeline, and runs it under freeze conditions. At each window end it drains the pipeline and commits the partial sum through a valid/ready psum handshake, with optional read-accumulate. Additions over the prior controller: configurable pipeline depth, explicit drain phase, handshake watchdog, and status outputs.

## Interface
- `FILTER_ADDR_WIDTH`, default 8: width of `filter_waddr`.
- `PIPE_DEPTH`, default 3, minimum 2: pipeline stages from read to `ld_result`.
- `WAIT_LIMIT`, default 255, minimum 1: maximum cycles spent waiting in a psum handshake state.
- `clk` in 1: single clock, rising edge.
- `reset` in 1: synchronous, active-high.
- `start` in 1: run request; the sequence begins on its falling edge.
- `IF_empty`, `reading_empty` in 1: IFMAP buffer status.
- `filter_cannot_read` in 1: filter buffer underflow.
- `filter_waddr` in `FILTER_ADDR_WIDTH`: filter write count; 0 means no filter loaded.
- `sp_valid` in 1: start pointer found.
- `f_co`, `go_next_stride`, `stride_ended`, `ended`, `go_next_filter`, `is_last_filter` in 1 each: traversal flags.
- `psum_mode` in 1: accumulate with the stored psum before writing.
- `psum_valid` in 1: psum read data valid.
- `psum_ready` in 1: psum write accepted.
- `psum_w_co` in 1: psum write address wrapped, meaning the layer is complete.
- `error` in 1: external fault.
- Outputs, 1 bit each unless stated:
  - `chip_en`, `global_rst`, `en_p_traverse`, `ren`, `ld_IF`, `i_en`, `mult_en`, `ld_result`
  - `en_f_counter`, `rst_f_counter`, `next_stride`, `next_filter`, `rst_stride`, `next_start`
  - `make_empty`, `rst_if_ctx` (resets stride_ended, is_last_filter, current_filter, p_valid)
  - `psum_ren`, `psum_wen`, `next_psum_raddr`, `next_psum_waddr`, `rst_psum_raddr`
  - `done`, `stall_signal`, `busy`, `timeout_err`
  - `fill_level` out `$clog2(PIPE_DEPTH+1)`: number of valid pipeline stages.

## Operation
- `freeze = reading_empty | filter_cannot_read | !sp_valid`. `run = !freeze & !f_co`.
- States and transitions:
  - IDLE → ARM on `start`.
  - ARM: `global_rst=1`; stays while `start`, then → WAIT_DATA.
  - WAIT_DATA → FIND_SP when `!IF_empty && filter_waddr!=0`.
  - FIND_SP: `en_p_traverse=!sp_valid`; → FILL on `sp_valid`.
  - FILL: on each `!freeze` cycle assert `ren`, `ld_IF`, `i_en`, and `mult_en` if `fill_level>=1`; `fill_level` increments. → RUN when incrementing to `PIPE_DEPTH-1`.
  - RUN:
    - `ren`, `ld_IF`, `i_en`, `mult_en`, `ld_result`, `en_f_counter` all equal `run`.
    - `next_stride = run & go_next_stride & !stride_ended & !ended`.
    - `next_filter = rst_stride = !freeze & go_next_filter`.
    - `go_next_filter & is_last_filter` → NEXT_IF.
    - Otherwise `f_co & !freeze` → DRAIN.
  - DRAIN: `ld_result=1` and `mult_en=1` per cycle, no reads; `fill_level` decrements. → PSUM_RD at 0 if `psum_mode`, else → PSUM_WR.
  - PSUM_RD: `psum_ren=1` until `psum_valid`, then → PSUM_WR.
  - PSUM_WR: `psum_wen=1` until `psum_ready`. On acceptance, pulse `next_psum_waddr` and `rst_f_counter`, and pulse `next_psum_raddr` if `psum_mode`. Then → DONE if `psum_w_co`, else → FILL.
  - NEXT_IF: `make_empty`, `rst_if_ctx`, `rst_stride`, and `fill_level` cleared; → UPDATE_SP.
  - UPDATE_SP: `next_start=1`, `rst_psum_raddr=psum_mode`; → FILL.
  - DONE: `done=1` for one cycle; → IDLE.
  - ERROR: `stall_signal=1`; exits only via `reset`.
- `error` high in any state other than IDLE → ERROR next cycle. It overrides all other transitions.
- Watchdog: a wait counter counts cycles spent in PSUM_RD or PSUM_WR and clears on entry to either state. Reaching `WAIT_LIMIT` → ERROR with `timeout_err=1`, sticky until `reset`.
- `chip_en` = `busy` = 1 in every state except IDLE.

## Timing
- `reset` sampled at a rising edge forces: state IDLE, `fill_level=0`, wait counter 0, `timeout_err=0`. All outputs are 0 in the following cycle. This holds in any state, including mid-handshake.
- Outputs are combinational decodes of the registered state, counters, and current inputs. Strobes are valid in the cycle they are asserted.
- Without freeze, the minimum latency from FILL entry to the first `ld_result` is `PIPE_DEPTH-1` cycles.
- A window end costs `PIPE_DEPTH-1` drain cycles, plus 1 write cycle if `psum_ready` is already high. `psum_mode` adds at least 1 read cycle.
- Simultaneous conditions:
  - `f_co` together with `go_next_filter & is_last_filter`: NEXT_IF wins.
  - `psum_valid` or `psum_ready` in the same cycle as the watchdog limit: the handshake wins.
- Freeze in FILL or RUN holds all counters and strobes low; DRAIN ignores freeze.

## Test plan
- `PIPE_DEPTH=3`, no freeze: `start` pulse, then data ready and `sp_valid` → first `ld_result` 2 cycles after FILL entry. `f_co` → 2 DRAIN cycles, then `psum_wen` with `psum_ready=1` → `next_psum_waddr` pulse, return to FILL.
- `reading_empty` held 4 cycles mid-RUN → `ren`, `ld_IF`, and `ld_result` low exactly 4 cycles; `fill_level` unchanged.
- `psum_mode=1`, `psum_valid` arrives after 3 cycles, `psum_ready` after 2 cycles → `psum_ren` high 3 cycles, `psum_wen` high 2 cycles, one `next_psum_raddr` pulse.
- `psum_ready` held low with `WAIT_LIMIT=8` → ERROR after 8 cycles with `timeout_err=1` and `stall_signal=1`; `reset` → all outputs 0 next cycle.
- `go_next_filter & is_last_filter` while `f_co=1` → NEXT_IF then UPDATE_SP (`next_start` pulse) then FILL. A final write with `psum_w_co=1` → single `done` pulse, then IDLE.
- `PIPE_DEPTH=5` regression: drain is 4 cycles, and `fill_level` peaks at 4.
